pong_match_ctrl: RTL
====================

PONG_MATCH_CTRL -- requirements
Module: pong_match_ctrl

Interface
REQ-001 Parameter WIN_SCORE, default 7, points needed to win a match.
REQ-002 Parameter SCORE_W, default 4, width of each score counter.
REQ-003 Parameter SERVE_DELAY, default 60, frames between ball re-centre and ball release.
REQ-004 Parameter WIN_BY_TWO, default 0, when 1 a win also needs a lead of at least 2 points.
REQ-005 clk_i  input  1  system clock; the only clock.
REQ-006 rst_i  input  1  reset; synchronous, active-high.
REQ-007 new_frame_i  input  1  one-cycle pulse per video frame.
REQ-008 start_i  input  1  start key level; rising edge detected internally.
REQ-009 pause_i  input  1  pause key level; rising edge detected internally.
REQ-010 miss_left_i  input  1  one-cycle pulse; ball left the screen past the left paddle.
REQ-011 miss_right_i  input  1  one-cycle pulse; ball left the screen past the right paddle.
REQ-012 ball_run_o  output  1  high only in PLAY; enables ball position updates.
REQ-013 ball_reset_o  output  1  one-cycle pulse that re-centres the ball.
REQ-014 serve_dir_o  output  1  1 = serve toward the right player, 0 = serve toward the left player.
REQ-015 score_l_o, score_r_o  output  SCORE_W  scores of the left and right players.
REQ-016 state_o  output  3  current game_state_t encoding.
REQ-017 winner_o  output  1  valid in OVER only; 0 = left player won, 1 = right player won.

Function
REQ-018 States: IDLE, SERVE, PLAY, PAUSE, OVER. All outputs are registered and change on the clock edge after the triggering event.
REQ-019 IDLE: scores are held at 0. A start edge moves to SERVE with serve_dir_o=1.
REQ-020 ball_reset_o pulses for exactly one cycle, on the cycle the FSM enters SERVE.
REQ-021 SERVE: the frame counter clears on entry and increments on each new_frame_i. On the new_frame_i where the counter equals SERVE_DELAY-1, the FSM moves to PLAY. SERVE_DELAY=0 is treated as 1.
REQ-022 PLAY: a miss_left_i pulse increments score_r_o and sets serve_dir_o=0. A miss_right_i pulse increments score_l_o and sets serve_dir_o=1.
REQ-023 After a score, if the win rule holds the FSM moves to OVER; otherwise it moves to SERVE.
REQ-024 Win rule: the scorer's new score is at least WIN_SCORE, and (WIN_BY_TWO=0, or the scorer's new score is at least the opponent's score + 2).
REQ-025 miss_left_i and miss_right_i in the same cycle: no score change, serve_dir_o keeps its value, FSM moves to SERVE.
REQ-026 Scores saturate at 2^SCORE_W-1 and never wrap. An elaboration-time check fails if WIN_SCORE > 2^SCORE_W-1.
REQ-027 A pause edge in PLAY moves to PAUSE. A pause edge in PAUSE moves back to PLAY. Pause edges in other states are ignored.
REQ-028 PAUSE: ball_run_o=0; miss pulses and new_frame_i are ignored.
REQ-029 A miss and a pause edge in the same PLAY cycle: the miss has priority and the pause is dropped.
REQ-030 Start edges outside IDLE and OVER are ignored.
REQ-031 OVER: ball_run_o=0; scores and winner_o hold. A start edge moves to IDLE and clears both scores.
REQ-032 Each key edge detector registers the previous key level; the edge is current & ~previous.

Reset
REQ-033 Reset values: state IDLE, scores 0, frame counter 0, serve_dir_o=1, ball_run_o=0, ball_reset_o=0, winner_o=0.
REQ-034 Previous-key registers reset to 1, so a key held during reset produces no edge.
REQ-035 Reset asserted mid-operation in any state returns every register to its reset value on the next edge.

Structure
REQ-036 game_state_t (enum, 3 bits) and the WIN_SCORE, SERVE_DELAY and WIN_BY_TWO defaults live in sprite_pkg alongside the existing game constants.
REQ-037 Key edge detection is a sub-module key_edge, instantiated once for start_i and once for pause_i.
REQ-038 The frame counter width is $clog2(SERVE_DELAY+1).

Verification
REQ-039 Reset, then start edge -> 1 cycle later state=SERVE and ball_reset_o=1 for that single cycle; after exactly 60 new_frame_i pulses, state=PLAY and ball_run_o=1.
REQ-040 Seven miss_right_i pulses, each followed by the serve delay -> score_l_o=7, state=OVER, winner_o=0, ball_run_o=0.
REQ-041 WIN_BY_TWO=1, scores driven to 6-6, then miss_left_i -> 6-7 and SERVE; then miss_left_i -> 6-8 and OVER with winner_o=1.
REQ-042 In PLAY, miss_left_i and miss_right_i in the same cycle -> scores unchanged, serve_dir_o unchanged, state=SERVE.
REQ-043 Pause edge in PLAY -> PAUSE; miss_left_i while in PAUSE -> no score change; second pause edge -> PLAY.
REQ-044 start_i held high through reset release -> state stays IDLE; releasing and re-pressing start_i -> SERVE.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared game constants, match-control defaults and the game-state encoding.
package sprite_pkg;

    localparam int unsigned SCREEN_W  = 640;
    localparam int unsigned SCREEN_H  = 480;
    localparam int unsigned PADDLE_H  = 48;
    localparam int unsigned BALL_SIZE = 8;

    localparam int unsigned WIN_SCORE_DEF   = 7;
    localparam int unsigned SERVE_DELAY_DEF = 60;
    localparam int unsigned WIN_BY_TWO_DEF  = 0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_OVER  = 3'd4
    } game_state_t;

    // True when the scorer's new total ends the match.
    function automatic logic wins(input int unsigned scorer, input int unsigned opp,
                                  input int unsigned win_score, input logic by_two);
        return (scorer >= win_score) && (!by_two || (scorer >= opp + 2));
    endfunction

endpackage

// File: rtl/key_edge.sv
// Rising-edge detector for a key level; held-through-reset keys give no edge.
module key_edge (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk) begin
        if (rst) prev <= 1'b1;
        else     prev <= key;
    end

    assign rise = key & ~prev;

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match controller: serve timing, scoring, pause and game-over sequencing.
module pong_match_ctrl
    import sprite_pkg::*;
#(
    parameter int unsigned WIN_SCORE   = WIN_SCORE_DEF,
    parameter int unsigned SCORE_W     = 4,
    parameter int unsigned SERVE_DELAY = SERVE_DELAY_DEF,
    parameter int unsigned WIN_BY_TWO  = WIN_BY_TWO_DEF
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               new_frame_i,
    input  logic               start_i,
    input  logic               pause_i,
    input  logic               miss_left_i,
    input  logic               miss_right_i,
    output logic               ball_run_o,
    output logic               ball_reset_o,
    output logic               serve_dir_o,
    output logic [SCORE_W-1:0] score_l_o,
    output logic [SCORE_W-1:0] score_r_o,
    output logic [2:0]         state_o,
    output logic               winner_o
);

    // A zero serve delay behaves as a single frame.
    localparam int unsigned DELAY = (SERVE_DELAY == 0) ? 1 : SERVE_DELAY;
    localparam int unsigned CNT_W = (SERVE_DELAY == 0) ? 1 : $clog2(SERVE_DELAY + 1);
    localparam logic [CNT_W-1:0]   LAST      = CNT_W'(DELAY - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    if (WIN_SCORE > (2 ** SCORE_W) - 1) begin : g_bad_win_score
        $error("WIN_SCORE exceeds the largest score SCORE_W bits can hold");
    end

    game_state_t        state;
    logic [CNT_W-1:0]   frames;
    logic [SCORE_W-1:0] l_next;
    logic [SCORE_W-1:0] r_next;
    logic               l_win;
    logic               r_win;
    logic               start_rise;
    logic               pause_rise;

    key_edge u_start (.clk(clk_i), .rst(rst_i), .key(start_i), .rise(start_rise));
    key_edge u_pause (.clk(clk_i), .rst(rst_i), .key(pause_i), .rise(pause_rise));

    always_comb begin
        l_next = (score_l_o == SCORE_MAX) ? score_l_o : score_l_o + SCORE_W'(1);
        r_next = (score_r_o == SCORE_MAX) ? score_r_o : score_r_o + SCORE_W'(1);
        l_win  = wins(32'(l_next), 32'(score_r_o), WIN_SCORE, WIN_BY_TWO != 0);
        r_win  = wins(32'(r_next), 32'(score_l_o), WIN_SCORE, WIN_BY_TWO != 0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= ST_IDLE;
            frames       <= '0;
            score_l_o    <= '0;
            score_r_o    <= '0;
            serve_dir_o  <= 1'b1;
            ball_run_o   <= 1'b0;
            ball_reset_o <= 1'b0;
            winner_o     <= 1'b0;
        end else begin
            ball_reset_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    score_l_o <= '0;
                    score_r_o <= '0;
                    if (start_rise) begin
                        state        <= ST_SERVE;
                        serve_dir_o  <= 1'b1;
                        frames       <= '0;
                        ball_reset_o <= 1'b1;
                    end
                end
                ST_SERVE: begin
                    if (new_frame_i) begin
                        if (frames == LAST) begin
                            state      <= ST_PLAY;
                            ball_run_o <= 1'b1;
                            frames     <= '0;
                        end else begin
                            frames <= frames + CNT_W'(1);
                        end
                    end
                end
                ST_PLAY: begin
                    // Misses outrank a simultaneous pause edge.
                    if (miss_left_i && miss_right_i) begin
                        state        <= ST_SERVE;
                        ball_run_o   <= 1'b0;
                        ball_reset_o <= 1'b1;
                    end else if (miss_left_i) begin
                        score_r_o   <= r_next;
                        serve_dir_o <= 1'b0;
                        ball_run_o  <= 1'b0;
                        if (r_win) begin
                            state    <= ST_OVER;
                            winner_o <= 1'b1;
                        end else begin
                            state        <= ST_SERVE;
                            ball_reset_o <= 1'b1;
                        end
                    end else if (miss_right_i) begin
                        score_l_o   <= l_next;
                        serve_dir_o <= 1'b1;
                        ball_run_o  <= 1'b0;
                        if (l_win) begin
                            state    <= ST_OVER;
                            winner_o <= 1'b0;
                        end else begin
                            state        <= ST_SERVE;
                            ball_reset_o <= 1'b1;
                        end
                    end else if (pause_rise) begin
                        state      <= ST_PAUSE;
                        ball_run_o <= 1'b0;
                    end
                end
                ST_PAUSE: begin
                    if (pause_rise) begin
                        state      <= ST_PLAY;
                        ball_run_o <= 1'b1;
                    end
                end
                ST_OVER: begin
                    if (start_rise) begin
                        state     <= ST_IDLE;
                        score_l_o <= '0;
                        score_r_o <= '0;
                        winner_o  <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    ball_run_o <= 1'b0;
                end
            endcase
        end
    end

    assign state_o = state;

endmodule
